// File: rtl/rect_compositor.sv
// Composites NUM_RECTS prioritised, bouncing rectangles over a black background.
// Two-stage pixel pipeline (hit vector, then palette colour) plus a per-frame animation sweep.
module rect_compositor #(
    parameter int NUM_RECTS = 4,
    parameter int COORD_W   = 12,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic               pixclk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               draw_area_i,
    input  logic               animate,
    input  logic               go_animate,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_idx,
    input  logic [2:0]         cfg_field,
    input  logic [COORD_W-1:0] cfg_data,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               draw_area_o,
    output logic               busy,
    output logic               overrun
);

    // state | meaning
    // IDLE  | waiting for an enabled animate pulse
    // SWEEP | moving rectangle idx, one per cycle
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);
    localparam logic [2:0]         LAST  = 3'(NUM_RECTS - 1);

    logic [COORD_W-1:0] rx [NUM_RECTS];
    logic [COORD_W-1:0] ry [NUM_RECTS];
    logic [COORD_W-1:0] rw [NUM_RECTS];
    logic [COORD_W-1:0] rh [NUM_RECTS];
    logic [2:0]         col [NUM_RECTS];
    logic [3:0]         dx [NUM_RECTS];
    logic [3:0]         dy [NUM_RECTS];
    logic [NUM_RECTS-1:0] en, neg_x, neg_y;

    state_t     state;
    logic [2:0] idx;

    // Returns {direction_negative, new_position}; intermediate sum is wide enough never to wrap.
    function automatic logic [COORD_W:0] bounce(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] size,
        input logic [3:0]         spd,
        input logic               neg,
        input logic [COORD_W-1:0] lim
    );
        logic [COORD_W+1:0] far;
        logic [COORD_W-1:0] step;
        logic [COORD_W:0]   res;
        step = {{(COORD_W-4){1'b0}}, spd};
        far  = {2'b00, pos} + {2'b00, size} + {2'b00, step};
        if (size >= lim)
            res = {neg, {COORD_W{1'b0}}};
        else if (!neg)
            res = (far >= {2'b00, lim}) ? {1'b1, lim - size} : {1'b0, pos + step};
        else
            res = (pos < step) ? {1'b0, {COORD_W{1'b0}}} : {1'b1, pos - step};
        return res;
    endfunction

    function automatic logic [23:0] palette(input logic [2:0] c);
        logic [23:0] rgb;
        case (c)
            3'd1:    rgb = 24'hDB203E;
            3'd2:    rgb = 24'h4D191B;
            3'd3:    rgb = 24'hA8B043;
            3'd4:    rgb = 24'h2B3314;
            3'd5:    rgb = 24'hFFA900;
            3'd6:    rgb = 24'h472812;
            3'd7:    rgb = 24'hFFFFFF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (animate && go_animate) begin
                        state <= SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (animate)
                        overrun <= 1'b1;
                    if (idx == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [COORD_W-1:0] cur_x, cur_y, cur_w, cur_h;
    logic [3:0]         cur_dx, cur_dy;
    logic               cur_nx, cur_ny;
    logic [COORD_W:0]   bx, by;

    always_comb begin
        cur_x  = '0;
        cur_y  = '0;
        cur_w  = '0;
        cur_h  = '0;
        cur_dx = '0;
        cur_dy = '0;
        cur_nx = 1'b0;
        cur_ny = 1'b0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            if (idx == 3'(i)) begin
                cur_x  = rx[i];
                cur_y  = ry[i];
                cur_w  = rw[i];
                cur_h  = rh[i];
                cur_dx = dx[i];
                cur_dy = dy[i];
                cur_nx = neg_x[i];
                cur_ny = neg_y[i];
            end
        end
        bx = bounce(cur_x, cur_w, cur_dx, cur_nx, H_LIM);
        by = bounce(cur_y, cur_h, cur_dy, cur_ny, V_LIM);
    end

    // Config write is applied after the sweep update so it wins for its own field.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            en    <= '0;
            neg_x <= '0;
            neg_y <= '0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                rx[i]  <= '0;
                ry[i]  <= '0;
                rw[i]  <= '0;
                rh[i]  <= '0;
                col[i] <= '0;
                dx[i]  <= '0;
                dy[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (state == SWEEP && idx == 3'(i) && en[i]) begin
                    rx[i]    <= bx[COORD_W-1:0];
                    neg_x[i] <= bx[COORD_W];
                    ry[i]    <= by[COORD_W-1:0];
                    neg_y[i] <= by[COORD_W];
                end
                if (cfg_we && cfg_idx == 3'(i)) begin
                    case (cfg_field)
                        3'd0: rx[i] <= cfg_data;
                        3'd1: ry[i] <= cfg_data;
                        3'd2: rw[i] <= cfg_data;
                        3'd3: rh[i] <= cfg_data;
                        3'd4: begin
                            en[i]  <= cfg_data[3];
                            col[i] <= cfg_data[2:0];
                        end
                        3'd5: begin
                            dx[i]    <= cfg_data[3:0];
                            dy[i]    <= cfg_data[7:4];
                            neg_x[i] <= 1'b0;
                            neg_y[i] <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [NUM_RECTS-1:0] hit_c, hit_q;
    logic                 hs1, vs1, da1;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            hit_c[i] = en[i]
                && (x >= rx[i]) && ({1'b0, x} < ({1'b0, rx[i]} + {1'b0, rw[i]}))
                && (y >= ry[i]) && ({1'b0, y} < ({1'b0, ry[i]} + {1'b0, rh[i]}));
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            hit_q <= '0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            da1   <= 1'b0;
        end else begin
            hit_q <= hit_c;
            hs1   <= hsync_i;
            vs1   <= vsync_i;
            da1   <= draw_area_i;
        end
    end

    logic [2:0]  sel_col;
    logic [23:0] rgb_c;

    // Scan from the top index down so the lowest hitting index is the last assignment.
    always_comb begin
        sel_col = 3'd0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (hit_q[i])
                sel_col = col[i];
        end
        rgb_c = palette(sel_col);
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync_o     <= 1'b0;
            vsync_o     <= 1'b0;
            draw_area_o <= 1'b0;
        end else begin
            hsync_o     <= hs1;
            vsync_o     <= vs1;
            draw_area_o <= da1;
            if (da1)
                {red, green, blue} <= rgb_c;
            else
                {red, green, blue} <= 24'h000000;
        end
    end

endmodule

// File: tb/tb_rect_compositor.sv
// Directed bench for rect_compositor: table-driven pixel vectors plus hand-written
// sequences for pipeline latency, bounce animation, overrun, write collision and reset.
module tb_rect_compositor;

    logic        pixclk = 1'b0;
    logic        rst;
    logic [11:0] x, y;
    logic        hsync_i, vsync_i, draw_area_i;
    logic        animate, go_animate;
    logic        cfg_we;
    logic [2:0]  cfg_idx, cfg_field;
    logic [11:0] cfg_data;
    logic [7:0]  red, green, blue;
    logic        hsync_o, vsync_o, draw_area_o, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pixclk = ~pixclk;

    rect_compositor dut (
        .pixclk(pixclk), .rst(rst), .x(x), .y(y),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .draw_area_i(draw_area_i),
        .animate(animate), .go_animate(go_animate),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .red(red), .green(green), .blue(blue),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .draw_area_o(draw_area_o),
        .busy(busy), .overrun(overrun)
    );

    typedef struct packed {
        logic [11:0] px;
        logic [11:0] py;
        logic        da;
        logic [23:0] rgb;
    } vec_t;

    vec_t tab [16];

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hDB203E;
    localparam logic [23:0] GREEN = 24'hA8B043;
    localparam logic [23:0] BLACK = 24'h000000;

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pix(input string name, input logic [11:0] px, input logic [11:0] py,
                             input logic da, input logic [23:0] exp);
        x = px;
        y = py;
        draw_area_i = da;
        step();
        step();
        check(name, {red, green, blue}, exp);
    endtask

    task automatic cfg(input logic [2:0] i, input logic [2:0] f, input logic [11:0] d);
        cfg_we    = 1'b1;
        cfg_idx   = i;
        cfg_field = f;
        cfg_data  = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 20 && busy; k++)
            step();
        check(name, {23'd0, busy}, 24'd0);
    endtask

    task automatic anim(input string name);
        animate    = 1'b1;
        go_animate = 1'b1;
        step();
        animate = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] hp, vp, dp;

        tab[0]  = '{12'd100, 12'd50, 1'b1, WHITE};
        tab[1]  = '{12'd119, 12'd59, 1'b1, WHITE};
        tab[2]  = '{12'd99,  12'd50, 1'b1, BLACK};
        tab[3]  = '{12'd120, 12'd50, 1'b1, BLACK};
        tab[4]  = '{12'd110, 12'd49, 1'b1, BLACK};
        tab[5]  = '{12'd110, 12'd60, 1'b1, BLACK};
        tab[6]  = '{12'd110, 12'd55, 1'b0, BLACK};
        tab[7]  = '{12'd105, 12'd52, 1'b1, WHITE};
        tab[8]  = '{12'd110, 12'd55, 1'b1, RED};
        tab[9]  = '{12'd125, 12'd55, 1'b1, GREEN};
        tab[10] = '{12'd134, 12'd61, 1'b1, GREEN};
        tab[11] = '{12'd135, 12'd55, 1'b1, BLACK};
        tab[12] = '{12'd134, 12'd62, 1'b1, BLACK};
        tab[13] = '{12'd100, 12'd50, 1'b1, RED};
        tab[14] = '{12'd119, 12'd59, 1'b1, RED};
        tab[15] = '{12'd120, 12'd59, 1'b1, GREEN};

        rst = 1'b1;
        x = '0; y = '0;
        hsync_i = 1'b1; vsync_i = 1'b1; draw_area_i = 1'b1;
        animate = 1'b0; go_animate = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_data = '0;
        step();
        step();
        check("reset_rgb", {red, green, blue}, BLACK);
        check("reset_sync", {21'd0, hsync_o, vsync_o, draw_area_o}, 24'd0);
        check("reset_status", {22'd0, busy, overrun}, 24'd0);
        rst = 1'b0;

        // Unconfigured frame: RGB stays black, syncs come out two cycles late.
        hp = 10'b1011001110;
        vp = 10'b0110101001;
        dp = 10'b1100110101;
        for (int k = 0; k < 10; k++) begin
            hsync_i = hp[k];
            vsync_i = vp[k];
            draw_area_i = dp[k];
            x = 12'(k * 50);
            y = 12'(k * 20);
            step();
            if (k >= 1) begin
                check($sformatf("sync_dly%0d", k), {21'd0, hsync_o, vsync_o, draw_area_o},
                      {21'd0, hp[k-1], vp[k-1], dp[k-1]});
                check($sformatf("blank_rgb%0d", k), {red, green, blue}, BLACK);
            end
        end
        hsync_i = 1'b0; vsync_i = 1'b0;

        cfg(0, 0, 12'd100);
        cfg(0, 1, 12'd50);
        cfg(0, 2, 12'd20);
        cfg(0, 3, 12'd10);
        cfg(0, 4, 12'h00F);
        cfg(5, 0, 12'd0);

        check_pix("lat_pre", 12'd99, 12'd55, 1'b1, BLACK);
        x = 12'd100;
        step();
        check("lat_1cyc", {red, green, blue}, BLACK);
        step();
        check("lat_2cyc", {red, green, blue}, WHITE);

        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                cfg(0, 4, 12'h009);
                cfg(1, 0, 12'd105);
                cfg(1, 1, 12'd52);
                cfg(1, 2, 12'd30);
                cfg(1, 3, 12'd10);
                cfg(1, 4, 12'h00B);
            end
            check_pix($sformatf("vec%0d", i), tab[i].px, tab[i].py, tab[i].da, tab[i].rgb);
        end

        // Horizontal bounce at the right edge.
        cfg(0, 0, 12'd615);
        cfg(0, 5, 12'h008);
        anim("sweep1_done");
        check_pix("bx1_in", 12'd620, 12'd55, 1'b1, RED);
        check_pix("bx1_out", 12'd619, 12'd55, 1'b1, BLACK);
        check_pix("bx1_edge", 12'd639, 12'd59, 1'b1, RED);
        anim("sweep2_done");
        check_pix("bx2_in", 12'd612, 12'd55, 1'b1, RED);
        check_pix("bx2_out", 12'd611, 12'd55, 1'b1, BLACK);
        check_pix("bx2_hi", 12'd631, 12'd55, 1'b1, RED);
        check_pix("bx2_hiout", 12'd632, 12'd55, 1'b1, BLACK);

        // Vertical bounce: first at the bottom to get direction -, then at the top.
        cfg(1, 0, 12'd0);
        cfg(1, 1, 12'd468);
        cfg(1, 2, 12'd10);
        cfg(1, 3, 12'd10);
        cfg(1, 5, 12'h050);
        anim("sweep3_done");
        check_pix("by1_in", 12'd5, 12'd470, 1'b1, GREEN);
        check_pix("by1_out", 12'd5, 12'd469, 1'b1, BLACK);
        check_pix("by1_edge", 12'd9, 12'd479, 1'b1, GREEN);
        cfg(1, 1, 12'd3);

        // Second animate two cycles into the sweep: overrun, no restart.
        animate = 1'b1;
        go_animate = 1'b1;
        step();
        animate = 1'b0;
        check("ov_busy1", {23'd0, busy}, 24'd1);
        step();
        check("ov_busy2", {23'd0, busy}, 24'd1);
        animate = 1'b1;
        step();
        animate = 1'b0;
        check("ov_busy3", {23'd0, busy}, 24'd1);
        check("ov_flag", {23'd0, overrun}, 24'd1);
        step();
        check("ov_busy4", {23'd0, busy}, 24'd1);
        step();
        check("ov_busy_end", {23'd0, busy}, 24'd0);
        step();
        check("ov_no_restart", {23'd0, busy}, 24'd0);
        check_pix("by2_top", 12'd5, 12'd0, 1'b1, GREEN);
        check_pix("by2_in", 12'd5, 12'd9, 1'b1, GREEN);
        check_pix("by2_out", 12'd5, 12'd10, 1'b1, BLACK);

        // Config write of rect1.x on the very edge rect1 is swept.
        animate = 1'b1;
        step();
        animate = 1'b0;
        step();
        cfg(1, 0, 12'd200);
        wait_idle("sweep5_done");
        check_pix("col_x", 12'd200, 12'd5, 1'b1, GREEN);
        check_pix("col_xlo", 12'd199, 12'd5, 1'b1, BLACK);
        check_pix("col_ylo", 12'd200, 12'd4, 1'b1, BLACK);
        check_pix("col_far", 12'd209, 12'd14, 1'b1, GREEN);
        check_pix("col_xhi", 12'd210, 12'd14, 1'b1, BLACK);

        animate = 1'b1;
        go_animate = 1'b0;
        step();
        animate = 1'b0;
        check("gate_off", {23'd0, busy}, 24'd0);
        check_pix("gate_nomove", 12'd200, 12'd5, 1'b1, GREEN);

        // Reset in the middle of a sweep.
        animate = 1'b1;
        go_animate = 1'b1;
        step();
        animate = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy", {23'd0, busy}, 24'd0);
        check("rst_overrun", {23'd0, overrun}, 24'd0);
        step();
        check("rst_aborted", {23'd0, busy}, 24'd0);
        check_pix("rst_r1", 12'd200, 12'd5, 1'b1, BLACK);
        check_pix("rst_r0", 12'd600, 12'd55, 1'b1, BLACK);
        cfg(1, 4, 12'h00B);
        check_pix("rst_zero_wh", 12'd0, 12'd0, 1'b1, BLACK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
